// File: rtl/pong_pkg.sv
// Shared Pong definitions: game states, default geometry and the debug view
// of the game state exported by pong_game.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  localparam int DEF_WIDTH        = 640;
  localparam int DEF_HEIGHT       = 480;
  localparam int DEF_PADDLE_W     = 8;
  localparam int DEF_PADDLE_H     = 64;
  localparam int DEF_PADDLE_XL    = 16;
  localparam int DEF_PADDLE_XR    = 616;
  localparam int DEF_BALL         = 8;
  localparam int DEF_BALL_SPEED   = 2;
  localparam int DEF_PADDLE_SPEED = 4;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_SCORE_MAX    = 9;

  // Snapshot of the game FSM and object positions; dx/dy are 1 for the
  // positive direction (right/down).
  typedef struct packed {
    game_state_t state;
    logic [7:0]  serve_cnt;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        ball_dx;
    logic        ball_dy;
    logic [9:0]  pad_l;
    logic [9:0]  pad_r;
  } pong_dbg_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous button input.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pong_game.sv
// Pong game logic and pixel generator: per-frame paddle/ball/score update
// and combinational colour for the current VGA pixel.
module pong_game
  import pong_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int HEIGHT       = DEF_HEIGHT,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int PADDLE_XL    = DEF_PADDLE_XL,
  parameter int PADDLE_XR    = DEF_PADDLE_XR,
  parameter int BALL         = DEF_BALL,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int SCORE_MAX    = DEF_SCORE_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vsync,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       btn_start,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output pong_dbg_t  dbg
);

  // 11-bit constants so every position compare/add is overflow-free.
  localparam logic [10:0] W11      = 11'(WIDTH);
  localparam logic [10:0] H11      = 11'(HEIGHT);
  localparam logic [10:0] PW11     = 11'(PADDLE_W);
  localparam logic [10:0] PH11     = 11'(PADDLE_H);
  localparam logic [10:0] XL11     = 11'(PADDLE_XL);
  localparam logic [10:0] XR11     = 11'(PADDLE_XR);
  localparam logic [10:0] B11      = 11'(BALL);
  localparam logic [10:0] BS11     = 11'(BALL_SPEED);
  localparam logic [10:0] PS11     = 11'(PADDLE_SPEED);
  localparam logic [10:0] PMAX11   = 11'(HEIGHT - PADDLE_H);
  localparam logic [10:0] LINE_X0  = 11'(WIDTH / 2 - 1);
  localparam logic [10:0] LINE_X1  = 11'(WIDTH / 2);
  localparam logic [9:0]  BX_C     = 10'((WIDTH - BALL) / 2);
  localparam logic [9:0]  BY_C     = 10'((HEIGHT - BALL) / 2);
  localparam logic [9:0]  PAD_INIT = 10'((HEIGHT - PADDLE_H) / 2);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]  SMAX     = 4'(SCORE_MAX);

  logic l_up, l_dn, r_up, r_dn, start;

  btn_sync u_sync_l_up  (.clk(clk), .reset(reset), .d(btn_l_up),  .q(l_up));
  btn_sync u_sync_l_dn  (.clk(clk), .reset(reset), .d(btn_l_dn),  .q(l_dn));
  btn_sync u_sync_r_up  (.clk(clk), .reset(reset), .d(btn_r_up),  .q(r_up));
  btn_sync u_sync_r_dn  (.clk(clk), .reset(reset), .d(btn_r_dn),  .q(r_dn));
  btn_sync u_sync_start (.clk(clk), .reset(reset), .d(btn_start), .q(start));

  logic vsync_q;
  logic tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_q <= 1'b1;
    else       vsync_q <= vsync;
  end

  assign tick = vsync_q & ~vsync;

  game_state_t state;
  logic [7:0]  serve_cnt;
  logic [9:0]  ball_x, ball_y, pad_l, pad_r;
  logic        dx, dy;

  logic [10:0] bx, by, pl, pr;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign pl = {1'b0, pad_l};
  assign pr = {1'b0, pad_r};

  logic [9:0] pad_l_nxt, pad_r_nxt;

  always_comb begin
    pad_l_nxt = pad_l;
    pad_r_nxt = pad_r;
    if (l_up && !l_dn)
      pad_l_nxt = (pl < PS11) ? 10'd0 : 10'(pl - PS11);
    else if (l_dn && !l_up)
      pad_l_nxt = (pl + PS11 > PMAX11) ? 10'(PMAX11) : 10'(pl + PS11);
    if (r_up && !r_dn)
      pad_r_nxt = (pr < PS11) ? 10'd0 : 10'(pr - PS11);
    else if (r_dn && !r_up)
      pad_r_nxt = (pr + PS11 > PMAX11) ? 10'(PMAX11) : 10'(pr + PS11);
  end

  logic [9:0] ball_x_nxt, ball_y_nxt;
  logic       dx_nxt, dy_nxt;
  logic       ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

  // Collisions are judged against the paddle positions held before this tick.
  always_comb begin
    ovl_l  = (by < pl + PH11) && (pl < by + B11);
    ovl_r  = (by < pr + PH11) && (pr < by + B11);
    hit_l  = !dx && (bx >= XL11 + PW11) && (bx - BS11 <= XL11 + PW11) && ovl_l;
    hit_r  = dx && (bx + B11 <= XR11) && (bx + B11 + BS11 >= XR11) && ovl_r;
    miss_l = !dx && (bx < BS11);
    miss_r = dx && (bx + B11 + BS11 > W11);

    dy_nxt = dy;
    if (!dy && by < BS11) begin
      ball_y_nxt = 10'd0;
      dy_nxt     = 1'b1;
    end else if (dy && by + B11 + BS11 > H11) begin
      ball_y_nxt = 10'(H11 - B11);
      dy_nxt     = 1'b0;
    end else begin
      ball_y_nxt = dy ? 10'(by + BS11) : 10'(by - BS11);
    end

    dx_nxt = dx;
    if (hit_l) begin
      ball_x_nxt = 10'(XL11 + PW11);
      dx_nxt     = 1'b1;
    end else if (hit_r) begin
      ball_x_nxt = 10'(XR11 - B11);
      dx_nxt     = 1'b0;
    end else begin
      ball_x_nxt = dx ? 10'(bx + BS11) : 10'(bx - BS11);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SERVE;
      serve_cnt <= 8'd0;
      pad_l     <= PAD_INIT;
      pad_r     <= PAD_INIT;
      ball_x    <= BX_C;
      ball_y    <= BY_C;
      dx        <= 1'b1;
      dy        <= 1'b1;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
    end else if (tick) begin
      case (state)
        SERVE: begin
          pad_l  <= pad_l_nxt;
          pad_r  <= pad_r_nxt;
          ball_x <= BX_C;
          ball_y <= BY_C;
          if (serve_cnt == SERVE_LAST) begin
            serve_cnt <= 8'd0;
            state     <= PLAY;
          end else begin
            serve_cnt <= serve_cnt + 8'd1;
          end
        end
        PLAY: begin
          pad_l <= pad_l_nxt;
          pad_r <= pad_r_nxt;
          if (miss_l || miss_r) begin
            // The ball re-serves toward whoever just conceded.
            ball_x <= BX_C;
            ball_y <= BY_C;
            dx     <= miss_r;
            if (miss_l) score_r <= score_r + 4'd1;
            else        score_l <= score_l + 4'd1;
            if ((miss_l ? score_r : score_l) + 4'd1 == SMAX) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end else begin
            ball_x <= ball_x_nxt;
            ball_y <= ball_y_nxt;
            dx     <= dx_nxt;
            dy     <= dy_nxt;
          end
        end
        GAME_OVER: begin
          if (start) begin
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            ball_x    <= BX_C;
            ball_y    <= BY_C;
            dx        <= 1'b1;
            state     <= SERVE;
            game_over <= 1'b0;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  logic [10:0] px, py;
  logic        offscreen, on_ball, on_pad, on_line;

  assign px        = {1'b0, x};
  assign py        = {1'b0, y};
  assign offscreen = (px >= W11) || (py >= H11);
  assign on_ball   = (px >= bx) && (px < bx + B11) && (py >= by) && (py < by + B11);
  assign on_pad    = ((px >= XL11) && (px < XL11 + PW11) && (py >= pl) && (py < pl + PH11)) ||
                     ((px >= XR11) && (px < XR11 + PW11) && (py >= pr) && (py < pr + PH11));
  assign on_line   = ((px == LINE_X0) || (px == LINE_X1)) && !y[4];

  always_comb begin
    red   = 4'h0;
    green = 4'h0;
    blue  = 4'h0;
    if (!offscreen) begin
      if (on_ball || on_pad) begin
        red   = 4'hF;
        green = 4'hF;
        blue  = 4'hF;
      end else if (on_line) begin
        red   = 4'h8;
        green = 4'h8;
        blue  = 4'h8;
      end else if (state == GAME_OVER) begin
        red = 4'h4;
      end
    end
  end

  always_comb begin
    dbg.state     = state;
    dbg.serve_cnt = serve_cnt;
    dbg.ball_x    = ball_x;
    dbg.ball_y    = ball_y;
    dbg.ball_dx   = dx;
    dbg.ball_dy   = dy;
    dbg.pad_l     = pad_l;
    dbg.pad_r     = pad_r;
  end

endmodule

// File: tb/tb_pong_game.sv
// Bench for pong_game: directed frames plus randomized buttons, checked
// against a frame-level game model after every tick.
module tb_pong_game;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       vsync;
  logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start;
  logic [3:0] red, green, blue, score_l, score_r;
  logic       game_over;
  pong_dbg_t  dbg;

  pong_game dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .vsync(vsync),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up),
    .btn_r_dn(btn_r_dn), .btn_start(btn_start),
    .red(red), .green(green), .blue(blue),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .dbg(dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference game, one call per frame, plain integer geometry.
  game_state_t m_state;
  int m_cnt, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_go;

  task automatic model_reset();
    m_state = SERVE; m_cnt = 0;
    m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_go = 0;
  endtask

  function automatic int pad_move(input int p, input bit up, input bit dn);
    if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
    return p;
  endfunction

  function automatic bit rows_meet(input int by, input int p);
    return (by < p + 64) && (p < by + 8);
  endfunction

  task automatic model_tick(input bit lu, ld, ru, rd, st);
    int pl0, pr0;
    pl0 = m_pl; pr0 = m_pr;
    if (m_state != GAME_OVER) begin
      m_pl = pad_move(m_pl, lu, ld);
      m_pr = pad_move(m_pr, ru, rd);
    end
    case (m_state)
      SERVE: begin
        m_cnt++;
        if (m_cnt == 60) begin m_cnt = 0; m_state = PLAY; end
      end
      PLAY: begin
        if ((m_dx < 0 && m_bx < 2) || (m_dx > 0 && m_bx + 10 > 640)) begin
          if (m_dx < 0) m_sr++; else m_sl++;
          m_bx = 316; m_by = 236;
          if (m_sl == 9 || m_sr == 9) begin m_state = GAME_OVER; m_go = 1; end
          else m_state = SERVE;
        end else begin
          if (m_dy < 0 && m_by < 2) begin m_by = 0; m_dy = 1; end
          else if (m_dy > 0 && m_by + 10 > 480) begin m_by = 472; m_dy = -1; end
          else m_by = m_by + 2 * m_dy;
          if (m_dx < 0 && m_bx >= 24 && m_bx - 2 <= 24 && rows_meet(m_by_prev(m_by, m_dy, pl0), pl0))
            begin m_bx = 24; m_dx = 1; end
          else if (m_dx > 0 && m_bx + 8 <= 616 && m_bx + 10 >= 616 && rows_meet(m_by_prev(m_by, m_dy, pr0), pr0))
            begin m_bx = 608; m_dx = -1; end
          else m_bx = m_bx + 2 * m_dx;
        end
      end
      default: begin
        if (st) begin
          m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_dx = 1;
          m_state = SERVE; m_go = 0;
        end
      end
    endcase
  endtask

  // Paddle overlap is judged on the pre-tick ball row, saved before the move.
  int by_before;
  function automatic int m_by_prev(input int unused_by, input int unused_dy, input int unused_p);
    return by_before;
  endfunction

  function automatic logic [11:0] exp_pix(input int px, input int py);
    if (px >= 640 || py >= 480) return 12'h000;
    if (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8) return 12'hFFF;
    if (px >= 16 && px < 24 && py >= m_pl && py < m_pl + 64) return 12'hFFF;
    if (px >= 616 && px < 624 && py >= m_pr && py < m_pr + 64) return 12'hFFF;
    if ((px == 319 || px == 320) && (py % 32) < 16) return 12'h888;
    if (m_state == GAME_OVER) return 12'h400;
    return 12'h000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",     32'(dbg.state),     32'(m_state));
    check("serve_cnt", 32'(dbg.serve_cnt), 32'(m_cnt));
    check("ball_x",    32'(dbg.ball_x),    32'(m_bx));
    check("ball_y",    32'(dbg.ball_y),    32'(m_by));
    check("ball_dx",   32'(dbg.ball_dx),   32'(m_dx > 0));
    check("ball_dy",   32'(dbg.ball_dy),   32'(m_dy > 0));
    check("pad_l",     32'(dbg.pad_l),     32'(m_pl));
    check("pad_r",     32'(dbg.pad_r),     32'(m_pr));
    check("score_l",   32'(score_l),       32'(m_sl));
    check("score_r",   32'(score_r),       32'(m_sr));
    check("game_over", 32'(game_over),     32'(m_go));
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic [11:0] exp);
    x = 10'(px); y = 10'(py);
    #1;
    check(tag, 32'({red, green, blue}), 32'(exp));
  endtask

  // One frame: set buttons, let them through the synchroniser, pulse vsync
  // low for one cycle, then compare state and one pixel.
  task automatic frame(input bit lu, ld, ru, rd, st);
    int px, py;
    @(negedge clk);
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd; btn_start = st;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    by_before = m_by;
    model_tick(lu, ld, ru, rd, st);
    @(negedge clk);
    vsync = 1'b1;
    check_all();
    if ($urandom_range(0, 1) == 1) begin
      px = m_bx + int'($urandom_range(0, 11)) - 2;
      py = m_by + int'($urandom_range(0, 11)) - 2;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
    end else begin
      px = int'($urandom_range(0, 700));
      py = int'($urandom_range(0, 520));
    end
    pix("pixel", px, py, exp_pix(px, py));
  endtask

  initial begin
    bit lu, ld, ru, rd;
    reset = 1'b1; vsync = 1'b1; x = '0; y = '0;
    btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0; btn_start = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all();
    pix("pix_line_on",  320, 0,   12'h888);
    pix("pix_line_gap", 320, 16,  12'h000);
    pix("pix_ball",     316, 236, 12'hFFF);
    pix("pix_offscr",   650, 10,  12'h000);

    // Serve: right paddle driven up into the top stop, left holds both.
    for (int i = 0; i < 60; i++) frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("serve_to_play", 32'(dbg.state), 32'(PLAY));
    check("pad_r_sat",     32'(dbg.pad_r), 32'd0);
    check("pad_l_both",    32'(dbg.pad_l), 32'd208);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("first_x", 32'(dbg.ball_x), 32'd318);
    check("first_y", 32'(dbg.ball_y), 32'd238);

    for (int i = 0; i < 1200; i++)
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));

    // Paddles dodge the ball so points are scored until the game ends.
    for (int i = 0; i < 8000 && m_go == 0; i++) begin
      ld = (m_by < 208); lu = !ld;
      rd = ld; ru = lu;
      frame(lu, ld, ru, rd, 1'b0);
    end
    check("game_over_reached", 32'(game_over), 32'd1);
    pix("pix_go_bg", 100, 100, 12'h400);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("go_holds", 32'(dbg.state), 32'(GAME_OVER));
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_state", 32'(dbg.state), 32'(SERVE));
    check("restart_score", 32'({score_l, score_r}), 32'd0);
    for (int i = 0; i < 70; i++) frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
